ov7670_sccb_config: RTL and testbench

//  - SCCB (I2C-like, write-only) master that configures the OV7670 after power-up.
//  - Walks a table of {reg_addr, reg_val} words from an external synchronous ROM. Writes each

---
 rtl/ov7670_sccb_config_if.sv | 15 +
 rtl/ov7670_sccb_config.sv | 140 ++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_sccb_config_if.sv
// ov7670_sccb_config_if: configurator bundle (start/busy/done/nack, table ROM address/data, SIOC/SIOD pins); master = configurator
interface ov7670_sccb_config_if #(parameter int ROM_AW = 8);
  logic start, busy, done, nack;
  logic [ROM_AW-1:0] nack_addr, rom_addr;
  logic [15:0] rom_data;
  logic sioc, siod_o, siod_oe, siod_i;
  modport master (
    input start, rom_data, siod_i,
    output busy, done, nack, nack_addr, rom_addr, sioc, siod_o, siod_oe
  );
  modport slave (
    output start, rom_data, siod_i,
    input busy, done, nack, nack_addr, rom_addr, sioc, siod_o, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: SCCB write master walking a {reg,val} ROM table into the OV7670; ports axi_clk, aresetn (sync, low), bus (control/status, ROM, SIOC/SIOD)
module ov7670_sccb_config #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0] DEV_ID = 8'h42,
  parameter int ROM_AW = 8
) (
  input logic axi_clk,
  input logic aresetn,
  ov7670_sccb_config_if.master bus
);
  localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int MS = CLK_FREQ_HZ / 1000;
  localparam int QW = $clog2(QTR);
  localparam int MW = $clog2(MS);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, START_C, BITS, STOP, DELAY, DONE} state_t;
  state_t state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0] quar_q, quar_d;
  logic [4:0] bit_q, bit_d;
  logic [26:0] frame_q, frame_d;
  logic [7:0] ms_q, ms_d;
  logic [MW-1:0] cyc_q, cyc_d;
  logic [ROM_AW-1:0] addr_q, addr_d, naddr_q, naddr_d;
  logic busy_q, busy_d, done_q, done_d, nack_q, nack_d;
  logic [1:0] sync_q;
  logic qend, bend, xbit, last, cyc_end, sioc_c, oe_c;
  assign qend = qcnt_q == QW'(QTR - 1);
  assign bend = qend && quar_q == 2'd3;
  assign xbit = bit_q == 5'd8 || bit_q == 5'd17 || bit_q == 5'd26;
  assign last = &addr_q;
  assign cyc_end = cyc_q == MW'(MS - 1);
  always_ff @(posedge axi_clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      qcnt_q <= '0;
      quar_q <= '0;
      bit_q <= '0;
      frame_q <= '0;
      ms_q <= '0;
      cyc_q <= '0;
      addr_q <= '0;
      naddr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nack_q <= 1'b0;
      sync_q <= 2'b11;
    end else begin
      state_q <= state_d;
      qcnt_q <= qcnt_d;
      quar_q <= quar_d;
      bit_q <= bit_d;
      frame_q <= frame_d;
      ms_q <= ms_d;
      cyc_q <= cyc_d;
      addr_q <= addr_d;
      naddr_q <= naddr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      nack_q <= nack_d;
      sync_q <= {sync_q[0], bus.siod_i};
    end
  end
  // frame_q holds the 27 bus bits MSB first with 1s in the 9th-bit slots, so a 1 means "release SIOD"
  always_comb begin
    state_d = state_q;
    qcnt_d = qend ? '0 : qcnt_q + 1'b1;
    quar_d = qend ? quar_q + 2'd1 : quar_q;
    bit_d = bit_q;
    frame_d = frame_q;
    ms_d = ms_q;
    cyc_d = cyc_q;
    addr_d = addr_q;
    naddr_d = naddr_q;
    busy_d = busy_q;
    done_d = done_q;
    nack_d = nack_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = FETCH;
        addr_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        nack_d = 1'b0;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        qcnt_d = '0;
        quar_d = '0;
        bit_d = '0;
        cyc_d = '0;
        ms_d = bus.rom_data[7:0];
        frame_d = {DEV_ID, 1'b1, bus.rom_data[15:8], 1'b1, bus.rom_data[7:0], 1'b1};
        state_d = &bus.rom_data ? DONE : bus.rom_data[15:8] == 8'hF0 ? DELAY : START_C;
      end
      START_C: if (bend) state_d = BITS;
      BITS: begin
        if (xbit && quar_q == 2'd2 && qend && sync_q[1] && !nack_q) begin
          nack_d = 1'b1;
          naddr_d = addr_q;
        end
        if (bend) begin
          bit_d = bit_q + 5'd1;
          frame_d = frame_q << 1;
          if (bit_q == 5'd26) state_d = STOP;
        end
      end
      STOP: if (bend) begin
        state_d = last ? DONE : FETCH;
        addr_d = last ? addr_q : addr_q + 1'b1;
      end
      DELAY: begin
        cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
        ms_d = cyc_end ? ms_q - 8'd1 : ms_q;
        if (ms_q == 8'd0 || (ms_q == 8'd1 && cyc_end)) begin
          state_d = last ? DONE : FETCH;
          addr_d = last ? addr_q : addr_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
    // status flips together with entering DONE so busy=0 already in the DONE cycle
    if (state_d == DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end
  always_comb begin
    sioc_c = state_q == BITS ? quar_q[1] : state_q == STOP ? |quar_q : 1'b1;
    oe_c = state_q == START_C ? quar_q[1] : state_q == BITS ? ~frame_q[26] : state_q == STOP ? ~quar_q[1] : 1'b0;
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.nack = nack_q;
  assign bus.nack_addr = naddr_q;
  assign bus.rom_addr = addr_q;
  assign bus.sioc = sioc_c;
  assign bus.siod_o = 1'b0;
  assign bus.siod_oe = oe_c;
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: directed bench with ROM model, ack/nack SCCB slave and frame decoder
module tb_ov7670_sccb_config;
  localparam int WR = 116 * 4;
  localparam int MS = 4000;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [15:0] rom [256];
  logic [15:0] rom2 [4];
  logic ack_low = 1'b0, ps = 1'b1, pl = 1'b1, lv;
  logic ps2 = 1'b1, po2 = 1'b0;
  logic [27:0] sh = '0;
  int bitcnt = 0, nack_frame = -1, xfault = 0, starts2 = 0;
  logic [23:0] frames [$];
  ov7670_sccb_config_if #(.ROM_AW(8)) bus ();
  ov7670_sccb_config_if #(.ROM_AW(2)) bus2 ();
  ov7670_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(250_000), .DEV_ID(8'h42), .ROM_AW(8)) dut (
    .axi_clk(clk), .aresetn(rstn), .bus(bus)
  );
  ov7670_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(250_000), .DEV_ID(8'h42), .ROM_AW(2)) dut2 (
    .axi_clk(clk), .aresetn(rstn), .bus(bus2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];
  assign bus.siod_i = ~bus.siod_oe & ~ack_low;
  assign bus2.siod_i = ~bus2.siod_oe;
  always @(negedge clk) begin
    lv = ~bus.siod_oe & ~ack_low;
    if (ps && bus.sioc && pl && !lv) begin
      bitcnt = 0;
      ack_low = 1'b0;
    end else if (ps && bus.sioc && !pl && lv) begin
      frames.push_back({sh[27:20], sh[18:11], sh[9:2]});
    end else if (!ps && bus.sioc) begin
      sh = {sh[26:0], lv};
      if ((bitcnt == 8 || bitcnt == 17 || bitcnt == 26) && bus.siod_oe) xfault++;
      bitcnt++;
    end else if (ps && !bus.sioc) begin
      ack_low = (bitcnt == 8 || bitcnt == 17 || bitcnt == 26) && frames.size() != nack_frame;
    end
    ps = bus.sioc;
    pl = ~bus.siod_oe & ~ack_low;
  end
  always @(negedge clk) begin
    if (ps2 && bus2.sioc && !po2 && bus2.siod_oe) starts2++;
    ps2 = bus2.sioc;
    po2 = bus2.siod_oe;
  end
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask
  task automatic wait_done(inout int n, input int lim);
    while (!bus.done && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic load_single();
    foreach (rom[i]) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    frames.delete();
    nack_frame = -1;
    xfault = 0;
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.sioc, bus.siod_oe, bus.siod_o, bus.busy, bus.done, bus.nack} !== 6'b100000 || bus.rom_addr !== 8'd0 || bus.nack_addr !== 8'd0) begin
      fails++;
      $display("FAIL reset_dut got sioc=%b oe=%b o=%b busy=%b done=%b nack=%b addr=%0d naddr=%0d, want 1 0 0 0 0 0 0 0",
               bus.sioc, bus.siod_oe, bus.siod_o, bus.busy, bus.done, bus.nack, bus.rom_addr, bus.nack_addr);
    end
    tests++;
    if ({bus2.sioc, bus2.siod_oe, bus2.busy, bus2.done, bus2.nack} !== 5'b10000 || bus2.rom_addr !== 2'd0) begin
      fails++;
      $display("FAIL reset_dut2 got sioc=%b oe=%b busy=%b done=%b nack=%b addr=%0d, want 1 0 0 0 0 0",
               bus2.sioc, bus2.siod_oe, bus2.busy, bus2.done, bus2.nack, bus2.rom_addr);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_write();
    int n = 0;
    logic [23:0] f;
    load_single();
    pulse_start();
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL single_busy got busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    wait_done(n, 2000);
    tests++;
    if (n < WR || n > WR + 4) begin
      fails++;
      $display("FAIL single_latency got %0d cycles, want %0d..%0d", n, WR, WR + 4);
    end
    f = frames.size() == 1 ? frames[0] : 24'h0;
    tests++;
    if (frames.size() != 1 || f !== 24'h421280) begin
      fails++;
      $display("FAIL single_frame got %0d frames first=%h, want 1 frame 421280", frames.size(), f);
    end
    tests++;
    if (xfault != 0) begin
      fails++;
      $display("FAIL x_release got %0d driven 9th bits, want 0", xfault);
    end
    tests++;
    if ({bus.busy, bus.done, bus.nack, bus.sioc, bus.siod_oe} !== 5'b01010 || bus.rom_addr !== 8'd1) begin
      fails++;
      $display("FAIL single_end got busy=%b done=%b nack=%b sioc=%b oe=%b addr=%0d, want 0 1 0 1 0 1",
               bus.busy, bus.done, bus.nack, bus.sioc, bus.siod_oe, bus.rom_addr);
    end
  endtask
  task automatic test_nack();
    int n = 0;
    logic [23:0] f1, f2;
    foreach (rom[i]) rom[i] = 16'hFFFF;
    rom[0] = 16'h0A01;
    rom[1] = 16'h0B02;
    rom[2] = 16'h0C03;
    frames.delete();
    nack_frame = 1;
    pulse_start();
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL nack_done_clear got done=%b busy=%b, want 0 1", bus.done, bus.busy);
    end
    wait_done(n, 3 * WR + 200);
    tests++;
    if (bus.nack !== 1'b1 || bus.nack_addr !== 8'd1) begin
      fails++;
      $display("FAIL nack_flag got nack=%b nack_addr=%0d, want 1 1", bus.nack, bus.nack_addr);
    end
    f1 = frames.size() == 3 ? frames[1] : 24'h0;
    f2 = frames.size() == 3 ? frames[2] : 24'h0;
    tests++;
    if (frames.size() != 3 || f1 !== 24'h420B02 || f2 !== 24'h420C03) begin
      fails++;
      $display("FAIL nack_frames got %0d frames f1=%h f2=%h, want 3 420b02 420c03", frames.size(), f1, f2);
    end
    tests++;
    if (bus.done !== 1'b1 || bus.rom_addr !== 8'd3) begin
      fails++;
      $display("FAIL nack_end got done=%b addr=%0d, want 1 3", bus.done, bus.rom_addr);
    end
  endtask
  task automatic test_delay();
    int n = 0;
    int low = 0;
    logic [23:0] f;
    foreach (rom[i]) rom[i] = 16'hFFFF;
    rom[0] = 16'hF002;
    rom[1] = 16'h1101;
    frames.delete();
    nack_frame = -1;
    pulse_start();
    tests++;
    if (bus.nack !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL delay_clear got nack=%b done=%b, want 0 0", bus.nack, bus.done);
    end
    while (!bus.siod_oe && n < 2 * MS + 100) begin
      @(negedge clk);
      n++;
      if (!bus.sioc) low++;
    end
    tests++;
    if (n < 2 * MS + 8 || n > 2 * MS + 16 || low != 0) begin
      fails++;
      $display("FAIL delay_time got %0d cycles to START with %0d sioc-low cycles, want %0d+-4 and 0", n, low, 2 * MS + 12);
    end
    n = 0;
    wait_done(n, WR + 200);
    f = frames.size() == 1 ? frames[0] : 24'h0;
    tests++;
    if (frames.size() != 1 || f !== 24'h421101 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL delay_frame got %0d frames first=%h done=%b, want 1 421101 1", frames.size(), f, bus.done);
    end
  endtask
  task automatic test_start_ignored();
    int n = 0;
    logic [23:0] f;
    load_single();
    pulse_start();
    repeat (150) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    n += 2;
    wait_done(n, 2000);
    f = frames.size() == 1 ? frames[0] : 24'h0;
    tests++;
    if (n < WR || n > WR + 4) begin
      fails++;
      $display("FAIL ignore_latency got %0d cycles, want %0d..%0d", n, WR, WR + 4);
    end
    tests++;
    if (frames.size() != 1 || f !== 24'h421280 || bus.rom_addr !== 8'd1) begin
      fails++;
      $display("FAIL ignore_frame got %0d frames first=%h addr=%0d, want 1 421280 1", frames.size(), f, bus.rom_addr);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    logic [23:0] f;
    load_single();
    pulse_start();
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tests++;
    if ({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.nack} !== 5'b10000 || bus.rom_addr !== 8'd0) begin
      fails++;
      $display("FAIL midreset got sioc=%b oe=%b busy=%b done=%b nack=%b addr=%0d, want 1 0 0 0 0 0",
               bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.nack, bus.rom_addr);
    end
    ack_low = 1'b0;
    @(negedge clk);
    frames.delete();
    pulse_start();
    wait_done(n, 2000);
    f = frames.size() == 1 ? frames[0] : 24'h0;
    tests++;
    if (frames.size() != 1 || f !== 24'h421280 || bus.done !== 1'b1 || bus.rom_addr !== 8'd1) begin
      fails++;
      $display("FAIL midreset_restart got %0d frames first=%h done=%b addr=%0d, want 1 421280 1 1",
               frames.size(), f, bus.done, bus.rom_addr);
    end
  endtask
  task automatic test_rom_aw2();
    int n = 0;
    rom2[0] = 16'h1001;
    rom2[1] = 16'h2002;
    rom2[2] = 16'h3003;
    rom2[3] = 16'h4004;
    starts2 = 0;
    @(negedge clk) bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    while (!bus2.done && n < 5 * WR) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (starts2 != 4) begin
      fails++;
      $display("FAIL aw2_writes got %0d writes, want 4", starts2);
    end
    tests++;
    if ({bus2.done, bus2.busy, bus2.sioc, bus2.siod_oe} !== 4'b1010 || bus2.rom_addr !== 2'd3) begin
      fails++;
      $display("FAIL aw2_end got done=%b busy=%b sioc=%b oe=%b addr=%0d, want 1 0 1 0 3",
               bus2.done, bus2.busy, bus2.sioc, bus2.siod_oe, bus2.rom_addr);
    end
    tests++;
    if (bus2.nack !== 1'b1 || bus2.nack_addr !== 2'd0) begin
      fails++;
      $display("FAIL aw2_nack got nack=%b nack_addr=%0d, want 1 0", bus2.nack, bus2.nack_addr);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus2.start = 1'b0;
    foreach (rom[i]) rom[i] = 16'hFFFF;
    foreach (rom2[i]) rom2[i] = 16'hFFFF;
    test_reset();
    test_single_write();
    test_nack();
    test_delay();
    test_start_ignored();
    test_reset_mid();
    test_rom_aw2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
